// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : muldiv_pkg
//  Description : Shared types for the EX-stage multiply/divide scheduler.
//                muldiv_op_t encodes the req_op field; sched_state_t is the
//                scheduler FSM state.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_DIV_RUN = 2'b10,
        ST_DONE    = 2'b11
    } sched_state_t;

    // Divide ops have the upper opcode bit set.
    function automatic logic op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sched
//  Description : Sequences the shared multiply/divide units for EX-stage
//                MULT/MULTU/DIV/DIVU. Latches operands, drives a level
//                start/ready handshake, stalls EX while a unit is running,
//                holds the {hi,lo} result while the pipeline is stalled and
//                issues exactly one HI/LO write per instruction.
//  Ports       : clk, rst (async, active-high)
//                req_valid/req_op/src_a/src_b  - EX request
//                stall_in, flush               - pipeline control
//                unit_a/unit_b/unit_signed/unit_flush - shared unit operands
//                mul_start/mul_ready/mul_result - multiplier handshake
//                div_start/div_ready/div_result - divider handshake
//                busy_stall   - stall request to hazard unit
//                res_valid/res/hilo_we - result and HI/LO write strobe
//                timeout_err  - sticky abort flag
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_sched #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic [1:0]     req_op,
    input  logic [W-1:0]   src_a,
    input  logic [W-1:0]   src_b,
    input  logic           stall_in,
    input  logic           flush,
    output logic [W-1:0]   unit_a,
    output logic [W-1:0]   unit_b,
    output logic           unit_signed,
    output logic           unit_flush,
    output logic           mul_start,
    input  logic           mul_ready,
    input  logic [2*W-1:0] mul_result,
    output logic           div_start,
    input  logic           div_ready,
    input  logic [2*W-1:0] div_result,
    output logic           busy_stall,
    output logic           res_valid,
    output logic [2*W-1:0] res,
    output logic           hilo_we,
    output logic           timeout_err
);
    import muldiv_pkg::*;

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    sched_state_t  state;
    sched_state_t  state_next;
    logic [CW-1:0] run_cnt;
    muldiv_op_t    req_kind;
    logic          in_run;
    logic          accept;
    logic          div_by_zero;
    logic          unit_ready;
    logic          timeout_hit;

    assign req_kind    = muldiv_op_t'(req_op);
    assign in_run      = (state == ST_MUL_RUN) || (state == ST_DIV_RUN);
    assign accept      = (state == ST_IDLE) && req_valid && !flush;
    assign div_by_zero = op_is_div(req_kind) && (src_b == '0);

    // Only the unit that owns the current RUN state may complete it.
    assign unit_ready  = ((state == ST_MUL_RUN) && mul_ready) ||
                         ((state == ST_DIV_RUN) && div_ready);
    assign timeout_hit = in_run && !unit_ready && (run_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic. Flush has priority over ready and timeout.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (div_by_zero)
                        state_next = ST_DONE;
                    else if (op_is_div(req_kind))
                        state_next = ST_DIV_RUN;
                    else
                        state_next = ST_MUL_RUN;
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (flush)
                    state_next = ST_IDLE;
                else if (unit_ready)
                    state_next = ST_DONE;
                else if (timeout_hit)
                    state_next = ST_IDLE;
            end
            ST_DONE: begin
                if (flush || !stall_in)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mul_start   <= 1'b0;
            div_start   <= 1'b0;
            run_cnt     <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            unit_signed <= 1'b0;
            res         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_next;
            // Starts are registered from the next state so they are high
            // exactly for the cycles spent in the matching RUN state.
            mul_start <= (state_next == ST_MUL_RUN);
            div_start <= (state_next == ST_DIV_RUN);

            // Counter restarts at zero on every RUN entry and on completion.
            if (in_run && (state_next == state))
                run_cnt <= run_cnt + CW'(1);
            else
                run_cnt <= '0;

            if (accept) begin
                unit_a      <= src_a;
                unit_b      <= src_b;
                unit_signed <= ~req_op[0];
            end

            // Divide by zero bypasses the unit: {remainder, quotient}.
            if (accept && div_by_zero)
                res <= {src_a, {W{1'b1}}};
            else if ((state == ST_MUL_RUN) && mul_ready && !flush)
                res <= mul_result;
            else if ((state == ST_DIV_RUN) && div_ready && !flush)
                res <= div_result;

            if (timeout_hit && !flush)
                timeout_err <= 1'b1;
        end
    end

    assign busy_stall = accept || in_run;
    assign res_valid  = (state == ST_DONE);
    assign hilo_we    = (state == ST_DONE) && !stall_in && !flush;
    assign unit_flush = flush;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sched
//  Description : Self-checking bench for muldiv_sched. The bench plays both
//                arithmetic units, computes results with plain arithmetic and
//                derives the expected per-cycle outputs from the transaction
//                timeline of each instruction.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_sched;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0;
    logic        stall_in = 1'b0, flush = 1'b0;
    logic [31:0] unit_a, unit_b;
    logic        unit_signed, unit_flush;
    logic        mul_start, div_start;
    logic        mul_ready = 1'b0, div_ready = 1'b0;
    logic [63:0] mul_result = '0, div_result = '0;
    logic        busy_stall, res_valid, hilo_we, timeout_err;
    logic [63:0] res;

    always #5 clk = ~clk;

    muldiv_sched #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .stall_in(stall_in), .flush(flush),
        .unit_a(unit_a), .unit_b(unit_b), .unit_signed(unit_signed),
        .unit_flush(unit_flush), .mul_start(mul_start), .mul_ready(mul_ready),
        .mul_result(mul_result), .div_start(div_start), .div_ready(div_ready),
        .div_result(div_result), .busy_stall(busy_stall), .res_valid(res_valid),
        .res(res), .hilo_we(hilo_we), .timeout_err(timeout_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected outputs for the current cycle
    logic        e_busy = 1'b0, e_ms = 1'b0, e_ds = 1'b0, e_rv = 1'b0, e_we = 1'b0;
    logic        e_tmo = 1'b0, e_us = 1'b0;
    logic [63:0] e_res = '0;
    logic [31:0] e_ua = '0, e_ub = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {hi,lo} = {remainder,quotient} for divides.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     q, rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                q  = $signed(a) / $signed(b);
                rm = $signed(a) % $signed(b);
                return {rm, q};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        chk("busy_stall",  64'(busy_stall),  64'(e_busy));
        chk("mul_start",   64'(mul_start),   64'(e_ms));
        chk("div_start",   64'(div_start),   64'(e_ds));
        chk("res_valid",   64'(res_valid),   64'(e_rv));
        chk("hilo_we",     64'(hilo_we),     64'(e_we));
        chk("timeout_err", 64'(timeout_err), 64'(e_tmo));
        chk("unit_a",      64'(unit_a),      64'(e_ua));
        chk("unit_b",      64'(unit_b),      64'(e_ub));
        chk("unit_signed", 64'(unit_signed), 64'(e_us));
        chk("unit_flush",  64'(unit_flush),  64'(flush));
        if (e_rv) chk("res", res, e_res);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic b, input logic ms, input logic ds, input logic rv, input logic we);
        e_busy = b; e_ms = ms; e_ds = ds; e_rv = rv; e_we = we;
    endtask

    // Randomise every input that should not matter this cycle.
    task automatic noise();
        req_valid  = 1'($urandom);
        req_op     = 2'($urandom);
        src_a      = $urandom;
        src_b      = $urandom;
        stall_in   = 1'($urandom);
        mul_ready  = 1'($urandom);
        div_ready  = 1'($urandom);
        mul_result = {$urandom, $urandom};
        div_result = {$urandom, $urandom};
        flush      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            if (req_valid) flush = 1'b1;
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_busy",     64'(busy_stall),  64'd0);
        chk("rst_mul_start",64'(mul_start),   64'd0);
        chk("rst_div_start",64'(div_start),   64'd0);
        chk("rst_res",      res,              64'd0);
        chk("rst_res_valid",64'(res_valid),   64'd0);
        chk("rst_hilo_we",  64'(hilo_we),     64'd0);
        chk("rst_unit_a",   64'(unit_a),      64'd0);
        chk("rst_timeout",  64'(timeout_err), 64'd0);
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_ua = '0; e_ub = '0; e_us = 1'b0; e_tmo = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One instruction. lat: RUN cycle in which the unit raises ready (0 = never).
    // flush_at: 0 request cycle, 1..lat RUN cycles, after that DONE cycles.
    // rst_at: RUN cycle in which reset is pulsed (-1 = none).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int stall_n, input int flush_at, input int rst_at);
        logic [63:0] r;
        bit          dz, isdiv, rdy, fl, st;
        int          base;
        isdiv = op[1];
        dz    = isdiv && (b == 32'd0);
        r     = model(op, a, b);

        noise();
        mul_ready = 1'b0; div_ready = 1'b0;
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        flush     = (flush_at == 0);
        set_exp(flush_at != 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        if (flush_at == 0) return;
        e_ua = a; e_ub = b; e_us = ~op[0];

        base = 0;
        if (!dz) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                rdy = (lat != 0) && (k == lat);
                fl  = (flush_at == k);
                noise();
                flush = fl;
                if (isdiv) begin
                    div_ready = rdy;
                    if (rdy) div_result = r;
                end else begin
                    mul_ready = rdy;
                    if (rdy) mul_result = r;
                end
                set_exp(1'b1, !isdiv, isdiv, 1'b0, 1'b0);
                if (rst_at == k) begin
                    do_reset();
                    return;
                end
                tick();
                if (fl) return;
                if (rdy) break;
                if (lat == 0 && k == TIMEOUT) begin
                    e_tmo = 1'b1;
                    return;
                end
            end
            base = lat;
        end

        for (int j = 0; j <= stall_n; j++) begin
            st = (j < stall_n);
            fl = (flush_at == base + 1 + j);
            noise();
            stall_in = st;
            flush    = fl;
            if (j == stall_n) req_valid = 1'b1;   // must not be accepted here
            set_exp(1'b0, 1'b0, 1'b0, 1'b1, !st && !fl);
            e_res = r;
            tick();
            if (fl) return;
        end
    endtask

    initial begin
        int          op, lat, stl, fa;
        logic [31:0] a, b;

        // Pin the reference arithmetic itself.
        chk("model_mult", model(2'b00, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model_divu", model(2'b11, 32'd7, 32'd2), {32'd1, 32'd3});
        chk("model_div",  model(2'b10, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_multu",model(2'b01, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);
        chk("model_div0", model(2'b10, 32'd9, 32'd0), {32'd9, 32'hFFFF_FFFF});

        // Reset held for two edges with outputs expected at zero.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 4, 0, -1, -1);   // MULT -3*5
        idle(2);
        run_op(2'b11, 32'd7, 32'd2, 3, 3, -1, -1);           // DIVU 7/2, 3 stall cycles
        run_op(2'b10, 32'd9, 32'd0, 0, 1, -1, -1);           // DIV by zero
        run_op(2'b10, 32'd100, 32'd7, 5, 0, 5, -1);          // flush with div_ready
        idle(1);
        run_op(2'b00, 32'd12, 32'd13, 3, 2, 5, -1);          // flush in stalled DONE
        run_op(2'b01, 32'd4, 32'd4, 4, 0, 0, -1);            // flush in request cycle
        run_op(2'b00, 32'd6, 32'd7, 6, 0, 3, -1);            // flush mid-RUN
        run_op(2'b01, 32'd5, 32'd6, 0, 0, -1, -1);           // timeout abort
        idle(3);
        run_op(2'b10, 32'd50, 32'd5, 2, 1, -1, -1);          // works after timeout
        run_op(2'b00, 32'd11, 32'd12, 10, 0, -1, 3);         // reset mid MUL_RUN
        run_op(2'b00, 32'd11, 32'd12, 2, 0, -1, -1);         // accepted normally

        for (int n = 0; n < 200; n++) begin
            op  = $urandom_range(0, 3);
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op == 2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            lat = $urandom_range(1, 8);
            stl = $urandom_range(0, 3);
            fa  = -1;
            if ($urandom_range(0, 7) == 0)
                fa = $urandom_range(0, ((op >= 2 && b == 0) ? 0 : lat) + 1 + stl);
            run_op(2'(op), a, b, lat, stl, fa, -1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
